// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: datapath width, reset PC, NOP encoding, PC step.
// Also provides the helper that word-aligns a redirect target.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h4000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    // Byte offset bits of a jump target are dropped.
    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] pc
    );
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture register that keeps a fetched instruction while decode stalls.
// Ports: capture_i loads instr_i/pc_i, drain_i empties, flush_i empties (wins), valid_o/instr_o/pc_o.
module fetch_hold_buf
    import fetch_stage_pkg::XLEN;
#(
    parameter logic [XLEN-1:0] INIT_PC    = 32'h4000_0000,
    parameter logic [XLEN-1:0] INIT_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_i,
    input  logic            drain_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= INIT_INSTR;
            pc_q    <= INIT_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the 1-cycle instruction memory, feeds decode.
// Ports: clk/rst, stall, redirect_valid/redirect_pc in; imem_addr/imem_re out,
// imem_rdata in; instr/instr_pc/bubble out to decode.
module fetch_stage
    import fetch_stage_pkg::XLEN;
    import fetch_stage_pkg::PC_STEP;
    import fetch_stage_pkg::align_pc;
#(
    parameter logic [XLEN-1:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_re,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            bubble
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic            infl_valid_q, infl_valid_d;

    logic            redir;
    logic [XLEN-1:0] target;

    logic            hold_valid;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            hold_capture;

    // Gating with rst keeps outputs at reset values while rst is high.
    assign redir  = redirect_valid & ~rst;
    assign target = align_pc(redirect_pc);

    assign imem_addr = redir ? target : fetch_pc_q;
    assign imem_re   = (~stall | redirect_valid) & ~rst;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        infl_pc_d    = infl_pc_q;
        infl_valid_d = infl_valid_q;
        if (redir) begin
            fetch_pc_d   = target + PC_STEP;
            infl_pc_d    = target;
            infl_valid_d = 1'b1;
        end else if (!stall) begin
            fetch_pc_d   = fetch_pc_q + PC_STEP;
            infl_pc_d    = fetch_pc_q;
            infl_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            infl_pc_q    <= RESET_PC;
            infl_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            infl_pc_q    <= infl_pc_d;
            infl_valid_q <= infl_valid_d;
        end
    end

    // Memory data is only trustworthy the cycle after a read, so the
    // stalled instruction is copied once, on the first stalled cycle.
    assign hold_capture = stall & infl_valid_q & ~hold_valid & ~redir;

    fetch_hold_buf #(
        .INIT_PC    (RESET_PC),
        .INIT_INSTR (NOP_INSTR)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .capture_i (hold_capture),
        .drain_i   (~stall),
        .flush_i   (redir),
        .instr_i   (imem_rdata),
        .pc_i      (infl_pc_q),
        .valid_o   (hold_valid),
        .instr_o   (hold_instr),
        .pc_o      (hold_pc)
    );

    always_comb begin
        instr    = NOP_INSTR;
        instr_pc = infl_pc_q;
        bubble   = 1'b1;
        if (redir) begin
            instr_pc = target;
        end else if (hold_valid) begin
            instr    = hold_instr;
            instr_pc = hold_pc;
            bubble   = 1'b0;
        end else if (infl_valid_q) begin
            instr    = imem_rdata;
            bubble   = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus async-reset sequence.
// Memory model returns a PC-derived word on reads and random data otherwise.
module tb_fetch_stage;

    localparam logic [31:0] B   = 32'h4000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        bubble;

    int checks;
    int errors;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_re        (imem_re),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .bubble         (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        if (imem_re) imem_rdata <= mem_f(imem_addr);
        else         imem_rdata <= $urandom;
    end

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        re;
        logic        bub;
        logic [31:0] pc;
        logic        chk_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic s, input logic rv, input logic [31:0] rpc,
        input logic [31:0] addr, input logic re, input logic bub,
        input logic [31:0] pc, input logic cp
    );
        vec_t v;
        v.stall = s;   v.rv = rv;   v.rpc = rpc;
        v.addr = addr; v.re = re;   v.bub = bub;
        v.pc = pc;     v.chk_pc = cp;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] addr,
                           input logic re, input logic bub,
                           input logic [31:0] pc, input logic cp);
        chk({tag, " imem_addr"}, imem_addr, addr);
        chk({tag, " imem_re"}, {31'd0, imem_re}, {31'd0, re});
        chk({tag, " bubble"}, {31'd0, bubble}, {31'd0, bub});
        chk({tag, " instr"}, instr, bub ? NOP : mem_f(pc));
        if (cp) chk({tag, " instr_pc"}, instr_pc, pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        // reset release cycle
        add(0, 0, 0, B, 1, 1, B, 1);
        // straight line: 8 instructions
        for (int k = 1; k <= 8; k++)
            add(0, 0, 0, B + 32'(4 * k), 1, 0, B + 32'(4 * (k - 1)), 1);
        // 3-cycle stall on B+20, then release
        for (int k = 0; k < 3; k++)
            add(1, 0, 0, B + 32'h24, 0, 0, B + 32'h20, 1);
        add(0, 0, 0, B + 32'h24, 1, 0, B + 32'h20, 1);
        add(0, 0, 0, B + 32'h28, 1, 0, B + 32'h24, 1);
        // redirect to misaligned target
        add(0, 1, B + 32'h103, B + 32'h100, 1, 1, 0, 0);
        add(0, 0, 0, B + 32'h104, 1, 0, B + 32'h100, 1);
        add(0, 0, 0, B + 32'h108, 1, 0, B + 32'h104, 1);
        // stall fills hold, then redirect under stall
        add(1, 0, 0, B + 32'h10C, 0, 0, B + 32'h108, 1);
        add(1, 0, 0, B + 32'h10C, 0, 0, B + 32'h108, 1);
        add(1, 1, B + 32'h200, B + 32'h200, 1, 1, 0, 0);
        add(0, 0, 0, B + 32'h204, 1, 0, B + 32'h200, 1);
        // back-to-back redirects
        add(0, 1, B + 32'h302, B + 32'h300, 1, 1, 0, 0);
        add(0, 1, B + 32'h400, B + 32'h400, 1, 1, 0, 0);
        add(0, 0, 0, B + 32'h404, 1, 0, B + 32'h400, 1);
        // PC wrap
        add(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 0);
        add(0, 0, 0, 32'h0000_0000, 1, 0, 32'hFFFF_FFFC, 1);
        add(0, 0, 0, 32'h0000_0004, 1, 0, 32'h0000_0000, 1);
        add(1, 0, 0, 32'h0000_0008, 0, 0, 32'h0000_0004, 1);

        // reset state while rst is held
        @(posedge clk);
        #1;
        chk_out("reset", B, 0, 1, B, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].re,
                    vecs[i].bub, vecs[i].pc, vecs[i].chk_pc);
            @(posedge clk);
            #1;
        end

        // hold now holds PC 4; async reset mid-stall acts before next edge
        stall = 1'b1;
        redirect_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", B, 0, 1, B, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk_out("rst2_c0", B, 1, 1, B, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("rst2_c1", B + 32'h4, 1, 0, B, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
